// File: rtl/risc_pkg.sv
// ----------------------------------------------------------------------------
// risc_pkg: shared ALU operation encoding, RV32I opcodes and issue-stage types.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package risc_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_t         op;
        logic            illegal;
    } alu_req_t;

    // funct7[5] only selects SUB when the caller allows it (OP, not OP-IMM).
    function automatic alu_op_t arith_op(input logic [2:0] funct3,
                                         input logic       funct7_5,
                                         input logic       allow_sub);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (funct7_5 && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_decode.sv
// ----------------------------------------------------------------------------
// alu_decode: combinational RV32I field decode to ALU operands and operation.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_decode
    import risc_pkg::*;
(
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output alu_req_t        req
);

    always_comb begin
        req.a       = '0;
        req.b       = '0;
        req.op      = ALU_ADD;
        req.illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                req.a  = rs1_val;
                req.b  = rs2_val;
                req.op = arith_op(funct3, funct7_5, 1'b1);
            end
            OPC_OP_IMM: begin
                req.a  = rs1_val;
                req.b  = imm;
                req.op = arith_op(funct3, funct7_5, 1'b0);
            end
            OPC_LUI: begin
                req.b = imm;
            end
            OPC_AUIPC: begin
                req.a = pc;
                req.b = imm;
            end
            OPC_LOAD, OPC_STORE: begin
                req.a = rs1_val;
                req.b = imm;
            end
            // Link value: return address is the next sequential instruction.
            OPC_JAL, OPC_JALR: begin
                req.a = pc;
                req.b = 32'd4;
            end
            default: begin
                req.illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ----------------------------------------------------------------------------
// alu_issue: two-stage valid/ready pipeline registering ALU inputs and result.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_issue
    import risc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output alu_op_t         alu_op,
    input  logic [XLEN-1:0] alu_res,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            out_illegal
);

    alu_req_t dec_req;
    alu_req_t s1;
    logic     s1_valid;
    logic     s1_adv;
    logic     accept;

    alu_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .pc       (pc),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .imm      (imm),
        .req      (dec_req)
    );

    // in_ready depends on out_ready combinationally so a full pipe never bubbles.
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1.a       <= '0;
            s1.b       <= '0;
            s1.op      <= ALU_ADD;
            s1.illegal <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1       <= dec_req;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_illegal <= 1'b0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            out_res     <= alu_res;
            out_illegal <= s1.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign alu_a  = s1.a;
    assign alu_b  = s1.b;
    assign alu_op = s1.op;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ----------------------------------------------------------------------------
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural ALU.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue;
    import risc_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     op;
        logic        ill;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_t     alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .pc          (pc),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .imm         (imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_res     (alu_res),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_illegal (out_illegal)
    );

    function automatic logic [31:0] alu_fn(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_op, alu_a, alu_b);

    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] p, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] im);
        exp_t m;
        m.a = 0; m.b = 0; m.op = ALU_ADD; m.ill = 1'b0;
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            m.a = r1;
            m.b = (opc == 7'b0110011) ? r2 : im;
            case (f3)
                3'd0: m.op = (f7 && opc == 7'b0110011) ? ALU_SUB : ALU_ADD;
                3'd1: m.op = ALU_SLL;
                3'd2: m.op = ALU_SLT;
                3'd3: m.op = ALU_SLTU;
                3'd4: m.op = ALU_XOR;
                3'd5: m.op = f7 ? ALU_SRA : ALU_SRL;
                3'd6: m.op = ALU_OR;
                default: m.op = ALU_AND;
            endcase
        end else if (opc == 7'b0110111) begin
            m.b = im;
        end else if (opc == 7'b0010111) begin
            m.a = p; m.b = im;
        end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
            m.a = r1; m.b = im;
        end else if (opc == 7'b1101111 || opc == 7'b1100111) begin
            m.a = p; m.b = 32'd4;
        end else begin
            m.ill = 1'b1;
        end
        m.res = alu_fn(m.op, m.a, m.b);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, wait (bounded) for acceptance, then check S1 contents.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im);
        exp_t e;
        int   waited;
        bit   got;
        e = model(opc, f3, f7, p, r1, r2, im);
        opcode = opc; funct3 = f3; funct7_5 = f7;
        pc = p; rs1_val = r1; rs2_val = r2; imm = im;
        in_valid = 1'b1;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("s1_a", alu_a, e.a);
        check("s1_b", alu_b, e.b);
        check("s1_op", 32'(alu_op), 32'(e.op));
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_res", out_res, e.res);
                check("out_illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_res, held_a;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        pc = '0; rs1_val = '0; rs2_val = '0; imm = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op", 32'(alu_op), 32'(ALU_ADD));
        check("rst_out_res", out_res, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // SUB then two-cycle result latency
        send(7'b0110011, 3'd0, 1'b1, 0, 32'd10, 32'd3, 0);
        check("sub_op", 32'(alu_op), 32'(ALU_SUB));
        @(posedge clk); #1;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("sub_res", out_res, 32'd7);
        drain();

        send(7'b0010011, 3'd0, 1'b1, 0, 32'd1, 32'd99, 32'd5);
        send(7'b0010011, 3'd5, 1'b1, 0, 32'h8000_0000, 0, 32'h0000_0404);
        send(7'b0110111, 3'd0, 1'b0, 0, 32'd77, 32'd88, 32'h1234_5000);
        send(7'b0010111, 3'd0, 1'b0, 32'h100, 32'd5, 0, 32'h1000);
        send(7'b1101111, 3'd0, 1'b0, 32'h40, 32'd9, 0, 32'h800);
        send(7'b1100111, 3'd0, 1'b0, 32'h80, 32'd9, 0, 32'h10);
        send(7'b0000011, 3'd2, 1'b0, 0, 32'h2000, 0, 32'hFFFF_FFFC);
        send(7'b0100011, 3'd2, 1'b0, 0, 32'h3000, 32'd1, 32'd8);
        send(7'b1100011, 3'd0, 1'b0, 32'h44, 32'd1, 32'd2, 32'd16);
        send(7'b0110011, 3'd7, 1'b0, 0, 32'hF0F0_FFFF, 32'h0FF0_00FF, 0);
        for (int i = 0; i < 8; i++) begin
            send(($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $urandom);
        end
        drain();

        // Mid-stream stall: out_ready low while more instructions arrive
        send(7'b0110011, 3'd0, 1'b0, 0, 32'd100, 32'd1, 0);
        out_ready = 1'b0;
        fork
            begin
                send(7'b0110011, 3'd0, 1'b0, 0, 32'd200, 32'd2, 0);
                send(7'b0110011, 3'd4, 1'b0, 0, 32'd300, 32'd3, 0);
                send(7'b0110011, 3'd6, 1'b0, 0, 32'd400, 32'd4, 0);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                held_res = out_res;
                held_a = alu_a;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_res_hold", out_res, held_res);
                    check("stall_a_hold", alu_a, held_a);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                #1;
                check("unstall_in_ready", 32'(in_ready), 32'd1);
            end
        join
        drain();

        // Async reset with both stages full discards everything
        out_ready = 1'b0;
        send(7'b0110011, 3'd1, 1'b0, 0, 32'd1, 32'd4, 0);
        send(7'b0110011, 3'd0, 1'b1, 0, 32'd50, 32'd8, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_op", 32'(alu_op), 32'(ALU_ADD));
        check("arst_a", alu_a, 32'd0);
        check("arst_out_res", out_res, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_out", 32'(out_valid), 32'd0);
        end
        send(7'b0010011, 3'd0, 1'b0, 0, 32'd20, 0, 32'd22);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
